// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if: request/control bundle between the hazard logic and the stall controller.
interface hazard_stall_ctrl_if #(parameter int CNT_W = 16);
    logic             load_stall_req;
    logic             branch_taken;
    logic             mem_busy;
    logic             halt_req;
    logic             resume;
    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             exmem_we;
    logic             memwb_we;
    logic             halted;
    logic [CNT_W-1:0] stall_cycles;
    modport master (
        output load_stall_req, branch_taken, mem_busy, halt_req, resume,
        input  pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, memwb_we, halted, stall_cycles
    );
    modport slave (
        input  load_stall_req, branch_taken, mem_busy, halt_req, resume,
        output pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, memwb_we, halted, stall_cycles
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: maps stall/flush/freeze/halt requests to per-stage pipeline controls.
// Optional saturating stall counter built only when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_ctrl #(
    parameter int FLUSH_CYCLES   = 1,
    parameter int MAX_LOAD_STALL = 1,
    parameter int CNT_W          = 16
) (
    input logic               i_clk,
    input logic               i_rst_n,
    hazard_stall_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN, LSTALL, FLUSH, HALT} state_t;
    localparam logic [1:0] FL_RELOAD = 2'(FLUSH_CYCLES - 1);
    localparam logic [1:0] LS_MAX    = 2'(MAX_LOAD_STALL);
    state_t     r_state, w_next;
    logic [1:0] r_ls_cnt, w_ls_nxt, r_fl_cnt, w_fl_nxt;
    logic       w_pc_we, w_ifid_we, w_flush, w_bubble, w_ex_we, w_mw_we;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= RUN;
            r_ls_cnt <= '0;
            r_fl_cnt <= '0;
        end else begin
            r_state  <= w_next;
            r_ls_cnt <= w_ls_nxt;
            r_fl_cnt <= w_fl_nxt;
        end
    end
    always_comb begin
        w_next    = r_state;
        w_ls_nxt  = r_ls_cnt;
        w_fl_nxt  = r_fl_cnt;
        w_pc_we   = 1'b1;
        w_ifid_we = 1'b1;
        w_ex_we   = 1'b1;
        w_mw_we   = 1'b1;
        w_flush   = 1'b0;
        w_bubble  = 1'b0;
        if (r_state == HALT || bus.mem_busy || bus.halt_req) begin
            {w_pc_we, w_ifid_we, w_ex_we, w_mw_we} = 4'b0000;
            if (r_state == HALT) begin
                w_next = bus.resume ? RUN : HALT;
            end else if (!bus.mem_busy) begin
                w_next   = HALT;
                w_ls_nxt = '0;
                w_fl_nxt = '0;
            end
        end else if (bus.branch_taken || r_state == FLUSH) begin
            w_flush  = 1'b1;
            w_bubble = 1'b1;
            w_ls_nxt = '0;
            if (bus.branch_taken) begin
                w_next   = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
                w_fl_nxt = FL_RELOAD;
            end else begin
                w_next   = (r_fl_cnt == 2'd1) ? RUN : FLUSH;
                w_fl_nxt = r_fl_cnt - 2'd1;
            end
        end else if (bus.load_stall_req && (r_state == RUN || r_ls_cnt < LS_MAX)) begin
            // a sticky request still gets one release cycle after LS_MAX freezes
            w_pc_we   = 1'b0;
            w_ifid_we = 1'b0;
            w_bubble  = 1'b1;
            w_next    = LSTALL;
            w_ls_nxt  = r_ls_cnt + 2'd1;
        end else begin
            w_next   = RUN;
            w_ls_nxt = '0;
        end
    end
    assign bus.pc_we       = i_rst_n & w_pc_we;
    assign bus.ifid_we     = i_rst_n & w_ifid_we;
    assign bus.ifid_flush  = i_rst_n & w_flush;
    assign bus.idex_bubble = i_rst_n & w_bubble;
    assign bus.exmem_we    = i_rst_n & w_ex_we;
    assign bus.memwb_we    = i_rst_n & w_mw_we;
    assign bus.halted      = i_rst_n & (r_state == HALT);
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (!w_pc_we && r_cnt != {CNT_W{1'b1}})
            r_cnt <= r_cnt + CNT_W'(1);
    end
    assign bus.stall_cycles = r_cnt;
`else
    assign bus.stall_cycles = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed vectors pushed to a scoreboard queue, checked by a negedge monitor.
module tb_hazard_stall_ctrl;
    typedef struct {int id; logic [8:0] v;} exp_t;
    localparam logic [6:0] DEF = 7'b1100110;
    localparam logic [6:0] STL = 7'b0001110;
    localparam logic [6:0] FLO = 7'b1111110;
    localparam logic [6:0] FRZ = 7'b0000000;
    localparam logic [6:0] HLT = 7'b0000001;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    exp_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_step = 0;
    logic [1:0] exp_cnt = 2'd0;
    hazard_stall_ctrl_if #(.CNT_W(2)) bus();
    hazard_stall_ctrl #(.FLUSH_CYCLES(2), .MAX_LOAD_STALL(1), .CNT_W(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
    );
    always #5 clk = ~clk;
    // in = {load_stall_req, branch_taken, mem_busy, halt_req, resume}
    task automatic step(input logic rst, input logic [4:0] in, input logic [6:0] e);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n = rst;
        {bus.load_stall_req, bus.branch_taken, bus.mem_busy, bus.halt_req, bus.resume} = in;
        if (!rst) exp_cnt = 2'd0;
        n_step++;
        x.id = n_step;
        x.v  = {e, exp_cnt};
        q.push_back(x);
        if (PERF && rst && !e[6] && exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
    endtask
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t x;
            logic [8:0] got;
            x = q.pop_front();
            got = {bus.pc_we, bus.ifid_we, bus.ifid_flush, bus.idex_bubble,
                   bus.exmem_we, bus.memwb_we, bus.halted, bus.stall_cycles};
            n_chk++;
            if (got === x.v) n_pass++;
            else $display("FAIL step%0d outputs got=%b exp=%b", x.id, got, x.v);
        end
    end
    initial begin
        {bus.load_stall_req, bus.branch_taken, bus.mem_busy, bus.halt_req, bus.resume} = 5'b0;
        step(0, 5'b00000, FRZ);
        step(1, 5'b00000, DEF);
        step(1, 5'b10000, STL);
        step(1, 5'b10000, DEF);
        step(1, 5'b10000, STL);
        step(1, 5'b00000, DEF);
        step(1, 5'b11000, FLO);
        step(1, 5'b10000, FLO);
        step(1, 5'b00000, DEF);
        step(1, 5'b01000, FLO);
        repeat (4) step(1, 5'b00100, FRZ);
        step(1, 5'b00000, FLO);
        step(1, 5'b00000, DEF);
        step(1, 5'b00010, FRZ);
        step(1, 5'b00000, HLT);
        step(1, 5'b10000, HLT);
        step(1, 5'b01000, HLT);
        step(1, 5'b00100, HLT);
        step(1, 5'b00010, HLT);
        step(1, 5'b00001, HLT);
        step(1, 5'b00000, DEF);
        step(1, 5'b10000, STL);
        step(0, 5'b10000, FRZ);
        step(1, 5'b00000, DEF);
        step(1, 5'b10000, STL);
        step(1, 5'b10100, FRZ);
        step(1, 5'b10000, DEF);
        step(1, 5'b10000, STL);
        step(1, 5'b11000, FLO);
        step(1, 5'b00010, FRZ);
        step(1, 5'b00001, HLT);
        step(1, 5'b00000, DEF);
        step(1, 5'b01000, FLO);
        step(1, 5'b01000, FLO);
        step(1, 5'b00000, FLO);
        step(1, 5'b00000, DEF);
        step(1, 5'b00110, FRZ);
        step(1, 5'b00000, DEF);
        @(posedge clk);
        @(posedge clk);
        n_chk++;
        if (q.size() == 0 && n_chk == n_step + 1) n_pass++;
        else $display("FAIL drain pending=%0d checked=%0d issued=%0d", q.size(), n_chk - 1, n_step);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
